// File: rtl/io_timer_pkg.sv
// Shared constants for the io_timer bus-mapped timer/counter: register map,
// bit positions, widths and the prescaler limit helper.
package io_timer_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PS_W    = 3;
    localparam int unsigned PRE_W   = 8;
    localparam int unsigned CTRL_W  = 7;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CNT_LO = 3'd2;
    localparam logic [2:0] OFF_CNT_HI = 3'd3;
    localparam logic [2:0] OFF_CMP_LO = 3'd4;
    localparam logic [2:0] OFF_CMP_HI = 3'd5;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_MIE    = 1;
    localparam int unsigned CTRL_OIE    = 2;
    localparam int unsigned CTRL_CLR    = 3;
    localparam int unsigned CTRL_PS_LSB = 4;

    localparam int unsigned STAT_MF = 0;
    localparam int unsigned STAT_OF = 1;

    localparam logic [CNT_W-1:0] CMP_RST = 16'hFFFF;

    // Terminal value of the prescaler for a given PS setting: (1<<ps)-1.
    function automatic logic [PRE_W-1:0] ps_limit(input logic [PS_W-1:0] ps);
        return (PRE_W'(1) << ps) - PRE_W'(1);
    endfunction

endpackage

// File: rtl/io_timer_if.sv
// CPU data-memory/IO bus as seen by the timer, plus its interrupt line.
interface io_timer_if;

    logic [io_timer_pkg::ADDR_W-1:0] io_addr;
    logic [io_timer_pkg::DATA_W-1:0] io_wdata;
    logic                            io_we;
    logic                            io_re;
    logic [io_timer_pkg::DATA_W-1:0] io_rdata;
    logic                            io_rvalid;
    logic                            irq;

    modport master (
        output io_addr, io_wdata, io_we, io_re,
        input  io_rdata, io_rvalid, irq
    );

    modport slave (
        input  io_addr, io_wdata, io_we, io_re,
        output io_rdata, io_rvalid, irq
    );

endinterface

// File: rtl/timer_prescaler.sv
// Divides the clock by 2^ps while enabled; tick_c is high on the cycle whose
// rising edge should advance the counter.
module timer_prescaler
    import io_timer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [PS_W-1:0] ps,
    input  logic            clear,
    output logic            tick_c
);

    logic [PRE_W-1:0] p_q;
    logic [PRE_W-1:0] p_d;

    assign tick_c = en && (p_q == ps_limit(ps));

    always_comb begin
        p_d = p_q + PRE_W'(1);
        if (!en || clear || tick_c) begin
            p_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer/counter with compare, overflow and a level irq.
// BASE_ADDR must be 8-byte aligned; the low three address bits select a register.
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h1010
)
(
    input  logic        clk,
    input  logic        rst_n,
    io_timer_if.slave   bus
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              mf_q, mf_d;
    logic              of_q, of_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cmp_q, cmp_d;
    logic [DATA_W-1:0] temp_q, temp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              hit_c;
    logic [2:0]        off_c;
    logic              wr_c;
    logic              rd_c;
    logic              wr_ctrl_c;
    logic              tick_c;
    logic              match_c;
    logic              clr_c;
    logic [DATA_W-1:0] rd_mux_c;

    assign hit_c     = (bus.io_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign off_c     = bus.io_addr[2:0];
    assign wr_c      = bus.io_we && hit_c;
    assign rd_c      = bus.io_re && hit_c;
    assign wr_ctrl_c = wr_c && (off_c == OFF_CTRL);
    assign match_c   = (cnt_q == cmp_q);
    assign clr_c     = ctrl_q[CTRL_CLR];

    timer_prescaler u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ctrl_q[CTRL_EN]),
        .ps     (ctrl_q[CTRL_PS_LSB +: PS_W]),
        .clear  (wr_ctrl_c),
        .tick_c (tick_c)
    );

    // Read mux over pre-edge state.
    always_comb begin
        rd_mux_c = '0;
        case (off_c)
            OFF_CTRL:   rd_mux_c = {1'b0, ctrl_q};
            OFF_STATUS: rd_mux_c = {6'b0, of_q, mf_q};
            OFF_CNT_LO: rd_mux_c = cnt_q[7:0];
            OFF_CNT_HI: rd_mux_c = temp_q;
            OFF_CMP_LO: rd_mux_c = cmp_q[7:0];
            OFF_CMP_HI: rd_mux_c = cmp_q[15:8];
            default:    rd_mux_c = '0;
        endcase
    end

    // Next-state: later assignments carry priority (flag set over W1C, CPU CNT write over tick).
    always_comb begin
        ctrl_d   = ctrl_q;
        mf_d     = mf_q;
        of_d     = of_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        temp_d   = temp_q;
        rvalid_d = rd_c;
        rdata_d  = rd_c ? rd_mux_c : '0;

        if (wr_ctrl_c) begin
            ctrl_d = bus.io_wdata[CTRL_W-1:0];
        end

        if (wr_c && ((off_c == OFF_CNT_HI) || (off_c == OFF_CMP_HI))) begin
            temp_d = bus.io_wdata;
        end else if (rd_c && (off_c == OFF_CNT_LO)) begin
            temp_d = cnt_q[15:8];
        end

        if (wr_c && (off_c == OFF_STATUS)) begin
            if (bus.io_wdata[STAT_MF]) mf_d = 1'b0;
            if (bus.io_wdata[STAT_OF]) of_d = 1'b0;
        end

        if (tick_c) begin
            if (match_c) begin
                mf_d  = 1'b1;
                cnt_d = clr_c ? '0 : cnt_q + CNT_W'(1);
                if (!clr_c && (cnt_q == CMP_RST)) begin
                    of_d = 1'b1;
                end
            end else if (cnt_q == CMP_RST) begin
                of_d  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (wr_c && (off_c == OFF_CNT_LO)) begin
            cnt_d = {temp_q, bus.io_wdata};
        end
        if (wr_c && (off_c == OFF_CMP_LO)) begin
            cmp_d = {temp_q, bus.io_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            mf_q     <= 1'b0;
            of_q     <= 1'b0;
            cnt_q    <= '0;
            cmp_q    <= CMP_RST;
            temp_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            mf_q     <= mf_d;
            of_q     <= of_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            temp_q   <= temp_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.io_rdata  = rdata_q;
    assign bus.io_rvalid = rvalid_q;
    assign bus.irq       = (mf_q & ctrl_q[CTRL_MIE]) | (of_q & ctrl_q[CTRL_OIE]);

endmodule

// File: tb/tb_io_timer.sv
// Scoreboarded bench for io_timer: reads push expected {rvalid,rdata}, a
// negedge monitor pops and compares when the response cycle arrives.
module tb_io_timer;
    import io_timer_pkg::*;

    localparam logic [15:0] BASE = 16'h1010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_timer_if bus_if();

    io_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    logic       rd_pend;
    logic [8:0] mon_exp;
    string      mon_tag;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // A read strobe seen at an edge owes a response in the following cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 1'b0;
        else        rd_pend <= bus_if.io_re;
    end

    always @(negedge clk) begin
        if (rst_n && rd_pend) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 16'd1, 16'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, {7'b0, bus_if.io_rvalid, bus_if.io_rdata}, {7'b0, mon_exp});
            end
        end
    end

    // All bus tasks are entered on a negedge and return on the next negedge.
    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        bus_if.io_addr  = BASE + 16'(off);
        bus_if.io_wdata = d;
        bus_if.io_we    = 1'b1;
        @(negedge clk);
        bus_if.io_we    = 1'b0;
    endtask

    task automatic bus_read_raw(input logic [15:0] addr, input logic [8:0] e, input string tag);
        bus_if.io_addr = addr;
        bus_if.io_re   = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        bus_if.io_re   = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] off, input logic [7:0] d, input string tag);
        bus_read_raw(BASE + 16'(off), {1'b1, d}, tag);
    endtask

    task automatic bus_rw(input logic [2:0] off, input logic [7:0] d, input logic [7:0] e, input string tag);
        bus_if.io_addr  = BASE + 16'(off);
        bus_if.io_wdata = d;
        bus_if.io_we    = 1'b1;
        bus_if.io_re    = 1'b1;
        exp_q.push_back({1'b1, e});
        tag_q.push_back(tag);
        @(negedge clk);
        bus_if.io_we    = 1'b0;
        bus_if.io_re    = 1'b0;
    endtask

    logic [7:0] rst_vals [8];

    initial begin
        rst_vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        bus_if.io_addr  = '0;
        bus_if.io_wdata = '0;
        bus_if.io_we    = 1'b0;
        bus_if.io_re    = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_rvalid", 16'(bus_if.io_rvalid), 16'd0);
        check("rst_rdata",  16'(bus_if.io_rdata),  16'd0);
        check("rst_irq",    16'(bus_if.irq),       16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset register image and a miss just past the window.
        for (int i = 0; i < 8; i++) bus_read(3'(i), rst_vals[i], "rst_rd");
        bus_read_raw(16'h1018, 9'h000, "miss_rd");

        // Compare match with clear-on-match at PS=0.
        bus_write(OFF_CMP_HI, 8'h00);
        bus_write(OFF_CMP_LO, 8'h05);
        bus_write(OFF_CTRL,   8'h0B);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("irq_match", 16'(bus_if.irq), (k == 6) ? 16'd1 : 16'd0);
        end
        bus_read(OFF_CNT_LO, 8'h00, "cnt_after_match");
        bus_write(OFF_STATUS, 8'h01);
        check("irq_w1c", 16'(bus_if.irq), 16'd0);
        repeat (3) @(negedge clk);
        bus_write(OFF_STATUS, 8'h01);
        check("irq_set_beats_w1c", 16'(bus_if.irq), 16'd1);
        bus_read(OFF_STATUS, 8'h01, "status_set_beats_w1c");
        bus_write(OFF_CTRL,   8'h00);
        bus_write(OFF_STATUS, 8'h01);
        check("irq_cleared", 16'(bus_if.irq), 16'd0);

        // Direct CMP reads.
        bus_write(OFF_CMP_HI, 8'h12);
        bus_write(OFF_CMP_LO, 8'h34);
        bus_read(OFF_CMP_LO, 8'h34, "cmp_lo");
        bus_read(OFF_CMP_HI, 8'h12, "cmp_hi");

        // Overflow from 0xFFFE.
        bus_write(OFF_CTRL,   8'h05);
        bus_write(OFF_CNT_HI, 8'hFF);
        bus_write(OFF_CNT_LO, 8'hFE);
        @(negedge clk);
        check("irq_ovf_early", 16'(bus_if.irq), 16'd0);
        @(negedge clk);
        check("irq_ovf", 16'(bus_if.irq), 16'd1);
        bus_read(OFF_CNT_LO, 8'h00, "cnt_wrap_lo");
        bus_read(OFF_CNT_HI, 8'h00, "cnt_wrap_hi");
        bus_read(OFF_STATUS, 8'h02, "status_of");
        bus_write(OFF_CTRL,   8'h00);
        bus_write(OFF_STATUS, 8'h03);
        check("irq_ovf_cleared", 16'(bus_if.irq), 16'd0);

        // PS=3: one tick every 8 clocks; a CTRL write restarts the spacing.
        bus_write(OFF_CNT_HI, 8'h00);
        bus_write(OFF_CNT_LO, 8'h00);
        bus_write(OFF_CTRL,   8'h31);
        bus_read(OFF_CTRL, 8'h31, "ctrl_rd");
        repeat (5) @(negedge clk);
        bus_read(OFF_CNT_LO, 8'h00, "ps3_pre");
        bus_read(OFF_CNT_LO, 8'h00, "ps3_at");
        bus_read(OFF_CNT_LO, 8'h01, "ps3_post");
        bus_write(OFF_CTRL, 8'h31);
        repeat (6) @(negedge clk);
        bus_read(OFF_CNT_LO, 8'h01, "ps3_restart_pre");
        bus_read(OFF_CNT_LO, 8'h01, "ps3_restart_at");
        bus_read(OFF_CNT_LO, 8'h02, "ps3_restart_post");

        // Atomic 16-bit read across 0x00FF -> 0x0100.
        bus_write(OFF_CTRL,   8'h00);
        bus_write(OFF_CNT_HI, 8'h00);
        bus_write(OFF_CNT_LO, 8'hFD);
        bus_write(OFF_CTRL,   8'h01);
        repeat (2) @(negedge clk);
        bus_read(OFF_CNT_LO, 8'hFF, "atomic_lo");
        bus_read(OFF_CNT_HI, 8'h00, "atomic_hi");

        // Simultaneous write+read returns pre-write data.
        bus_rw(OFF_CTRL, 8'h00, 8'h01, "rw_pre_data");
        bus_read(OFF_CTRL, 8'h00, "rw_post_data");

        // Asynchronous reset with irq high and a read response in flight.
        bus_write(OFF_CNT_HI, 8'hFF);
        bus_write(OFF_CNT_LO, 8'hFF);
        bus_write(OFF_CTRL,   8'h05);
        bus_if.io_addr = BASE + 16'(OFF_CNT_LO);
        bus_if.io_re   = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_irq",    16'(bus_if.irq),       16'd1);
        check("pre_rst_rvalid", 16'(bus_if.io_rvalid), 16'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_irq",    16'(bus_if.irq),       16'd0);
        check("async_rst_rvalid", 16'(bus_if.io_rvalid), 16'd0);
        check("async_rst_rdata",  16'(bus_if.io_rdata),  16'd0);
        bus_if.io_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) bus_read(3'(i), rst_vals[i], "rst2_rd");

        repeat (3) @(negedge clk);
        check("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped 16-bit timer/counter that sits as a responder on the CPU's data-memory/IO bus and drives one of the CPU's `interrupt_N` inputs. It decodes a fixed 8-byte window in the IO page, answers single-byte reads with one-cycle latency and accepts single-byte writes. It counts prescaled clock ticks, compares against a programmable value and raises a level interrupt on match or overflow.

## Interface
- `BASE_ADDR`, 16'h1010, byte address of register offset 0; must be 8-aligned (`BASE_ADDR[2:0]==0`)
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `io_addr`  in  16  bus address from CPU
- `io_wdata`  in  8  bus write data from CPU
- `io_we`  in  1  write strobe, one cycle per access
- `io_re`  in  1  read strobe, one cycle per access
- `io_rdata`  out  8  read data, valid when `io_rvalid`=1, else 8'h00
- `io_rvalid`  out  1  registered "this block answered last cycle's read"
- `irq`  out  1  level interrupt request to CPU

## Operation
- Hit: `io_addr[15:3]==BASE_ADDR[15:3]`; offset = `io_addr[2:0]`. Accesses that miss are ignored.
- Offset 0 CTRL (rw): [0] EN, [1] MIE match-irq enable, [2] OIE overflow-irq enable, [3] CLR clear-on-match, [6:4] PS prescale, [7] reads 0.
- Offset 1 STATUS: [0] MF match flag, [1] OF overflow flag; write-1-to-clear; other bits read 0.
- Offset 2 CNT_LO, 3 CNT_HI; offset 4 CMP_LO, 5 CMP_HI; offsets 6–7 read 8'h00, writes ignored.
- 16-bit atomic access through one shared 8-bit TEMP:
  - Write HI (3 or 5): TEMP <= wdata.
  - Write LO (2 or 4): target <= {TEMP, wdata}.
  - Read CNT_LO: returns CNT[7:0]; TEMP <= CNT[15:8] in the same edge.
  - Read CNT_HI: returns TEMP.
  - CMP reads are direct; TEMP is unchanged.
- Prescaler: 8-bit counter P. Tick when EN and `P == (1<<PS)-1`; P then wraps to 0. P is held at 0 while EN=0 and is cleared on any CTRL write.
- On tick:
  - CNT==CMP: MF<=1; CNT <= CLR ? 0 : CNT+1.
  - Otherwise, if CNT==16'hFFFF: OF<=1; CNT<=0.
  - Otherwise: CNT <= CNT+1.
  - When CLR=0 and CMP=16'hFFFF, a match and an overflow happen on the same tick and set both flags. When CLR=1, a match suppresses overflow.
- `irq = (MF & MIE) | (OF & OIE)`, combinational from registers.
- Simultaneous events:
  - A CPU write to CNT_LO beats a tick increment in the same cycle.
  - A hardware flag set beats a W1C clear in the same cycle.
  - A CTRL write that clears EN stops the counter from the next edge.

## Timing
- Reset values:
  - CTRL=0, STATUS=0, CNT=0, CMP=16'hFFFF, TEMP=0, P=0.
  - `io_rdata`=0, `io_rvalid`=0, `irq`=0.
- Write: register updates on the edge where `io_we` and a hit are sampled. The effect is visible to a read issued the following cycle.
- Read: `io_re` plus a hit at edge N gives `io_rdata`/`io_rvalid` valid for exactly the cycle after edge N. The value reflects state before edge N. Otherwise 0/0.
- Tick to flag: the flag is set at the tick edge, and `irq` rises in the same cycle after that edge.
- PS=0 gives one tick per clock while EN=1; the first tick comes on the first edge after EN is seen as 1.
- `io_we` and `io_re` asserted together: the write is performed and the read returns pre-write data.
- Reset mid-operation: all state returns immediately to reset values; any read in flight is dropped.

## Structure
- Package `io_timer_pkg`: register offsets (OFF_CTRL..OFF_CMP_HI), CTRL bit indices, STATUS bit indices, CMP reset value.
- Sub-module `timer_prescaler`:
  - Inputs: clk, rst_n, en, ps[2:0], clear.
  - Output: a one-cycle tick pulse.
- Top level holds decode, TEMP logic, CNT/CMP/flags and the read-data register.

## Test plan
- Reset, then read offsets 0–7 → 00,00,00,00,FF,FF,00,00 with `io_rvalid`=1 one cycle after each `io_re`. A miss read at 16'h1018 → `io_rvalid`=0.
- Write CMP_HI=0x00, CMP_LO=0x05, CTRL=0x0B (EN, MIE, CLR, PS=0) → MF and `irq` rise 6 ticks after EN. CNT reads 0 at the next tick. Writing STATUS=0x01 drops `irq`.
- CTRL=0x05 (EN, OIE), write CNT_HI=0xFF then CNT_LO=0xFE → OF set and `irq`=1 two ticks later; CNT wraps to 0x0000.
- PS=3 with EN → CNT increments every 8 clocks. Writing CTRL mid-count restarts the 8-clock spacing.
- Counter running at PS=0: read CNT_LO, then CNT_HI across a 0x00FF→0x0100 rollover → the pair reads 0x00FF, not 0x01FF.
- W1C of MF on the same edge as a new match → MF stays 1. Assert rst_n low mid-count → all outputs 0 asynchronously.
